// File: rtl/core_boot_ctrl.sv
// core_boot_ctrl: sequences a core through program load and run.
// Holds the core in reset while streaming words into instruction memory
// over a valid/ready port, then releases it one cycle after the last write.
// Optional halt detection is enabled with macro CORE_BOOT_HALT_DET_EN.
// Ports: clk, rst (sync, active-low), start/abort/len (host control),
//   s_valid/s_data/s_ready (loader stream), im_wr/im_addr/im_data
//   (imem write port), core_rst (to core), instr_addr (core fetch addr),
//   busy/done/err/halted (status). All outputs are registered.
module core_boot_ctrl #(
   parameter int NBINST   = 15,
   parameter int MINSTW   = 9,
   parameter int MINSTS   = 512,
   parameter int HALT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [MINSTW:0]   len,
   input  logic              s_valid,
   input  logic [NBINST-1:0] s_data,
   output logic              s_ready,
   output logic              im_wr,
   output logic [MINSTW-1:0] im_addr,
   output logic [NBINST-1:0] im_data,
   output logic              core_rst,
   input  logic [MINSTW-1:0] instr_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              halted
);

   localparam int CW = MINSTW + 1;
   localparam logic [CW-1:0] MAXLEN = CW'(MINSTS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_RUN,
`ifdef CORE_BOOT_HALT_DET_EN
      S_HALT,
`endif
      S_ERR
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]     cnt, cnt_n;
   logic [CW-1:0]     len_q, len_n;
   logic              err_n;
   logic              wr_n;
   logic [MINSTW-1:0] addr_n;
   logic [NBINST-1:0] data_n;
   logic              len_ok;
   logic              hs;
   logic              halt_hit;

   assign len_ok = (len != '0) && (len <= MAXLEN);
   // s_ready is only ever high in LOAD, so this is the true handshake
   assign hs     = s_valid & s_ready;

`ifdef CORE_BOOT_HALT_DET_EN
   localparam int HW = $clog2(HALT_CYC + 1);
   localparam logic [HW-1:0] HMAX = HW'(HALT_CYC);

   logic [MINSTW-1:0] prev_addr;
   logic [HW-1:0]     same_cnt;

   assign halt_hit = (same_cnt == HMAX);

   // Outside RUN the count is held at zero, which clears it on RUN entry
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_addr <= '0;
         same_cnt  <= '0;
      end else begin
         prev_addr <= instr_addr;
         if (state != S_RUN)
            same_cnt <= '0;
         else if (instr_addr != prev_addr)
            same_cnt <= '0;
         else if (!halt_hit)
            same_cnt <= same_cnt + 1'b1;
      end
   end
`else
   logic unused_addr;
   assign unused_addr = ^instr_addr;
   assign halt_hit    = 1'b0;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      len_n   = len_q;
      err_n   = err;
      wr_n    = 1'b0;
      addr_n  = im_addr;
      data_n  = im_data;
      unique case (state)
         S_IDLE, S_ERR: begin
            if (abort && state == S_ERR) begin
               state_n = S_IDLE;
            end else if (start) begin
               if (len_ok) begin
                  state_n = S_LOAD;
                  cnt_n   = '0;
                  len_n   = len;
                  err_n   = 1'b0;
               end else begin
                  state_n = S_ERR;
                  err_n   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (hs) begin
               wr_n   = 1'b1;
               addr_n = cnt[MINSTW-1:0];
               data_n = s_data;
               cnt_n  = cnt + 1'b1;
               if (cnt == len_q - 1'b1)
                  state_n = S_DRAIN;
            end
         end
         S_DRAIN: state_n = abort ? S_IDLE : S_RUN;
         S_RUN: begin
            if (abort)
               state_n = S_IDLE;
`ifdef CORE_BOOT_HALT_DET_EN
            else if (halt_hit)
               state_n = S_HALT;
`endif
         end
`ifdef CORE_BOOT_HALT_DET_EN
         S_HALT: if (abort) state_n = S_IDLE;
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         len_q    <= '0;
         err      <= 1'b0;
         s_ready  <= 1'b0;
         im_wr    <= 1'b0;
         im_addr  <= '0;
         im_data  <= '0;
         core_rst <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         len_q    <= len_n;
         err      <= err_n;
         s_ready  <= (state_n == S_LOAD);
         im_wr    <= wr_n;
         im_addr  <= addr_n;
         im_data  <= data_n;
         core_rst <= (state_n != S_RUN);
         busy     <= (state_n == S_LOAD) || (state_n == S_DRAIN);
         done     <= (state == S_DRAIN) && (state_n == S_RUN);
      end
   end

`ifdef CORE_BOOT_HALT_DET_EN
   always_ff @(posedge clk) begin
      if (!rst) halted <= 1'b0;
      else      halted <= (state_n == S_HALT);
   end
`else
   assign halted = 1'b0;
`endif

endmodule
